// File: rtl/rv_mtimer_pkg.sv
// Shared types and default widths for the RISC-V machine-timer core.
package rv_mtimer_pkg;

  typedef enum logic {
    CmpOneShot  = 1'b0,
    CmpPeriodic = 1'b1
  } cmp_mode_e;

  localparam int MtimeW = 64;
  localparam int PrescW = 12;
  localparam int StepW  = 8;

endpackage

// File: rtl/rv_mtimer_cmp.sv
// One timer comparator channel: compare register, periodic reload with
// saturation on carry-out, registered expiry level and expiry pulse.
module rv_mtimer_cmp
  import rv_mtimer_pkg::*;
#(
  parameter int TW = MtimeW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] mtime,
  input  logic          we,
  input  logic [TW-1:0] wdata,
  input  logic          mode,
  input  logic [TW-1:0] period,
  output logic [TW-1:0] cmp,
  output logic          expired,
  output logic          pulse
);

  logic          sat;
  logic          ge;
  logic          reload;
  logic [TW:0]   sum;

  assign ge     = (mtime >= cmp);
  assign reload = (cmp_mode_e'(mode) == CmpPeriodic) && (period != '0) && !sat && ge;
  assign sum    = {1'b0, cmp} + {1'b0, period};

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp     <= '1;
      sat     <= 1'b0;
      expired <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      // A software write wins over a reload in the same cycle.
      if (we) begin
        cmp <= wdata;
        sat <= 1'b0;
      end else if (reload) begin
        if (sum[TW]) begin
          cmp <= '1;
          sat <= 1'b1;
        end else begin
          cmp <= sum[TW-1:0];
        end
      end

      if (reload) begin
        expired <= 1'b1;
        pulse   <= 1'b1;
      end else begin
        expired <= ge;
        pulse   <= ge & ~expired;
      end
    end
  end

endmodule

// File: rtl/rv_mtimer_core.sv
// Machine-timer core: prescaled, step-incremented mtime counter feeding
// N_CMP independent one-shot / periodic comparators.
module rv_mtimer_core
  import rv_mtimer_pkg::*;
#(
  parameter int N_CMP = 1,
  parameter int TW    = MtimeW,
  parameter int PW    = PrescW,
  parameter int SW    = StepW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                active_i,
  input  logic [PW-1:0]       prescaler_i,
  input  logic [SW-1:0]       step_i,
  input  logic                mtime_we_i,
  input  logic [TW-1:0]       mtime_wdata_i,
  output logic [TW-1:0]       mtime_o,
  output logic                tick_o,
  input  logic [N_CMP-1:0]    cmp_we_i,
  input  logic [TW-1:0]       cmp_wdata_i,
  input  logic [N_CMP-1:0]    mode_i,
  input  logic [N_CMP*TW-1:0] period_i,
  output logic [N_CMP*TW-1:0] cmp_o,
  output logic [N_CMP-1:0]    expired_o,
  output logic [N_CMP-1:0]    event_o
);

  logic [PW-1:0] pcnt;
  logic          tick;

  // Lowering prescaler_i below pcnt lets pcnt run on until it wraps.
  assign tick = active_i && (pcnt == prescaler_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt    <= '0;
      mtime_o <= '0;
      tick_o  <= 1'b0;
    end else begin
      tick_o <= tick;
      if (!active_i || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
      // A software load drops the increment of a coincident tick.
      if (mtime_we_i) begin
        mtime_o <= mtime_wdata_i;
      end else if (tick) begin
        mtime_o <= mtime_o + TW'(step_i);
      end
    end
  end

  for (genvar k = 0; k < N_CMP; k++) begin : g_cmp
    rv_mtimer_cmp #(
      .TW(TW)
    ) u_cmp (
      .clk    (clk_i),
      .rst    (rst_i),
      .mtime  (mtime_o),
      .we     (cmp_we_i[k]),
      .wdata  (cmp_wdata_i),
      .mode   (mode_i[k]),
      .period (period_i[k*TW +: TW]),
      .cmp    (cmp_o[k*TW +: TW]),
      .expired(expired_o[k]),
      .pulse  (event_o[k])
    );
  end

endmodule

// File: tb/tb_rv_mtimer_core.sv
// Self-checking bench for rv_mtimer_core: directed scenarios plus random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_rv_mtimer_core;

  localparam int N_CMP = 2;
  localparam int TW    = 12;
  localparam int PW    = 4;
  localparam int SW    = 4;
  localparam longint TMAX = (longint'(1) << TW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                active;
  logic [PW-1:0]       prescaler;
  logic [SW-1:0]       step;
  logic                mtime_we;
  logic [TW-1:0]       mtime_wdata;
  logic [TW-1:0]       mtime_o;
  logic                tick_o;
  logic [N_CMP-1:0]    cmp_we;
  logic [TW-1:0]       cmp_wdata;
  logic [N_CMP-1:0]    mode;
  logic [N_CMP*TW-1:0] period;
  logic [N_CMP*TW-1:0] cmp_o;
  logic [N_CMP-1:0]    expired_o;
  logic [N_CMP-1:0]    event_o;

  always #5 clk = ~clk;

  rv_mtimer_core #(.N_CMP(N_CMP), .TW(TW), .PW(PW), .SW(SW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .active_i     (active),
    .prescaler_i  (prescaler),
    .step_i       (step),
    .mtime_we_i   (mtime_we),
    .mtime_wdata_i(mtime_wdata),
    .mtime_o      (mtime_o),
    .tick_o       (tick_o),
    .cmp_we_i     (cmp_we),
    .cmp_wdata_i  (cmp_wdata),
    .mode_i       (mode),
    .period_i     (period),
    .cmp_o        (cmp_o),
    .expired_o    (expired_o),
    .event_o      (event_o)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [TW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  longint m_mtime, m_pcnt;
  bit     m_tick;
  longint m_cmp[N_CMP];
  bit     m_sat[N_CMP], m_exp[N_CMP], m_evt[N_CMP];

  function automatic void model_step();
    longint mt_old = m_mtime;
    longint per, nxt;
    bit tk, ge;
    if (rst) begin
      m_mtime = 0; m_pcnt = 0; m_tick = 0;
      for (int k = 0; k < N_CMP; k++) begin
        m_cmp[k] = TMAX; m_sat[k] = 0; m_exp[k] = 0; m_evt[k] = 0;
      end
      return;
    end
    tk     = active && (m_pcnt == longint'(prescaler));
    m_pcnt = (!active || tk) ? 0 : (m_pcnt + 1) % (longint'(1) << PW);
    m_tick = tk;
    if (mtime_we)  m_mtime = longint'(mtime_wdata);
    else if (tk)   m_mtime = (m_mtime + longint'(step)) % (TMAX + 1);
    for (int k = 0; k < N_CMP; k++) begin
      ge  = (mt_old >= m_cmp[k]);
      per = longint'(period[k*TW +: TW]);
      if (mode[k] && per != 0 && !m_sat[k] && ge) begin
        m_evt[k] = 1;
        m_exp[k] = 1;
        nxt = m_cmp[k] + per;
        if (nxt > TMAX) begin m_cmp[k] = TMAX; m_sat[k] = 1; end
        else m_cmp[k] = nxt;
      end else begin
        m_evt[k] = ge && !m_exp[k];
        m_exp[k] = ge;
      end
      if (cmp_we[k]) begin m_cmp[k] = longint'(cmp_wdata); m_sat[k] = 0; end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("mtime", 64'(mtime_o), 64'(m_mtime));
    check("tick", 64'(tick_o), 64'(m_tick));
    for (int k = 0; k < N_CMP; k++) begin
      check($sformatf("cmp%0d", k), 64'(cmp_o[k*TW +: TW]), 64'(m_cmp[k]));
      check($sformatf("expired%0d", k), 64'(expired_o[k]), 64'(m_exp[k]));
      check($sformatf("event%0d", k), 64'(event_o[k]), 64'(m_evt[k]));
    end
  endtask

  task automatic idle_inputs();
    active = 0; prescaler = '0; step = '0; mtime_we = 0; mtime_wdata = '0;
    cmp_we = '0; cmp_wdata = '0; mode = '0; period = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cycle(); rst = 0;
  endtask

  task automatic write_cmp(input int k, input logic [TW-1:0] v);
    cmp_wdata = v; cmp_we = '0; cmp_we[k] = 1'b1;
    cycle();
    cmp_we = '0;
  endtask

  task automatic load_mtime(input logic [TW-1:0] v);
    mtime_wdata = v; mtime_we = 1;
    cycle();
    mtime_we = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mtime"}, 64'(mtime_o), 64'd0);
    check({tag, "_tick"}, 64'(tick_o), 64'd0);
    check({tag, "_cmp"}, 64'(cmp_o), 64'({N_CMP*TW{1'b1}}));
    check({tag, "_expired"}, 64'(expired_o), 64'd0);
    check({tag, "_event"}, 64'(event_o), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_evt;
    int guard;
    logic [TW-1:0] v;

    idle_inputs();
    rst = 1; cycle(); cycle(); rst = 0;
    check_reset_values("reset");

    // Prescaler 3, step 2: ticks after active edges 4, 8, 12, 16, 20.
    do_reset();
    prescaler = 3; step = 2; active = 1;
    exp_q = '{4, 8, 12, 16, 20};
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (tick_o) begin
        if (exp_q.size() == 0) check("tick_extra", 64'(i), 64'd0);
        else check("tick_cycle", 64'(i), 64'(exp_q.pop_front()));
      end
    end
    check("tick_missing", 64'(exp_q.size()), 64'd0);
    check("mtime_after20", 64'(mtime_o), 64'd10);

    // One-shot at 0x10: a single event, visible while mtime reads 0x11.
    do_reset();
    write_cmp(0, 12'h010);
    step = 1; active = 1; n_evt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (event_o[0]) begin
        n_evt++;
        check("oneshot_rise", 64'(mtime_o), 64'h11);
      end
    end
    check("oneshot_count", 64'(n_evt), 64'd1);
    check("oneshot_level", 64'(expired_o[0]), 64'd1);

    // Periodic channel 1, cmp 0x20, period 0x10.
    do_reset();
    mode = 2'b10; period[TW +: TW] = 12'h010;
    write_cmp(1, 12'h020);
    step = 1; active = 1;
    exp_q = '{12'h030, 12'h040, 12'h050};
    for (int i = 0; i < 'h48; i++) begin
      cycle();
      if (event_o[1]) begin
        if (exp_q.size() == 0) check("periodic_extra", 64'(cmp_o[TW +: TW]), 64'd0);
        else begin
          v = exp_q.pop_front();
          check("periodic_cmp", 64'(cmp_o[TW +: TW]), 64'(v));
          check("periodic_mtime", 64'(mtime_o), 64'(v - 12'h010 + 12'h001));
        end
      end
    end
    check("periodic_missing", 64'(exp_q.size()), 64'd0);

    // Catch-up: cmp 8, period 4, mtime loaded to 20.
    do_reset();
    mode = 2'b01; period[0 +: TW] = 12'd4;
    write_cmp(0, 12'd8);
    load_mtime(12'd20);
    exp_q = '{12'd12, 12'd16, 12'd20, 12'd24};
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (event_o[0]) begin
        if (exp_q.size() == 0) check("catchup_extra", 64'(cmp_o[0 +: TW]), 64'd0);
        else check("catchup_cmp", 64'(cmp_o[0 +: TW]), 64'(exp_q.pop_front()));
      end
    end
    check("catchup_missing", 64'(exp_q.size()), 64'd0);
    check("catchup_final_cmp", 64'(cmp_o[0 +: TW]), 64'd24);
    check("catchup_event_low", 64'(event_o[0]), 64'd0);

    // Reload carry-out saturates, then a rewrite restores periodic reload.
    do_reset();
    mode = 2'b01; period[0 +: TW] = 12'h010;
    load_mtime(12'hFF0);
    write_cmp(0, 12'hFF8);
    step = 1; active = 1; n_evt = 0;
    for (int i = 0; i < 'h17; i++) begin
      cycle();
      if (event_o[0]) n_evt++;
    end
    check("sat_cmp", 64'(cmp_o[0 +: TW]), 64'hFFF);
    check("sat_events", 64'(n_evt), 64'd2);
    write_cmp(0, 12'h040);
    guard = 0;
    while (mtime_o != 12'h046 && guard < 200) begin
      cycle();
      guard++;
    end
    check("sat_wait", 64'(mtime_o), 64'h046);
    check("sat_restored", 64'(cmp_o[0 +: TW]), 64'h050);

    // Load and tick together, cmp write during a reload, then mid-run reset.
    do_reset();
    mode = 2'b01; period[0 +: TW] = 12'd1;
    write_cmp(0, 12'h010);
    load_mtime(12'h050);
    cycle(); cycle();
    active = 1; prescaler = 0; step = 1;
    mtime_wdata = 12'h100; mtime_we = 1;
    cmp_wdata = 12'h077; cmp_we = 2'b01;
    cycle();
    mtime_we = 0; cmp_we = '0;
    check("same_cycle_mtime", 64'(mtime_o), 64'h100);
    check("same_cycle_cmp", 64'(cmp_o[0 +: TW]), 64'h077);
    cycle(); cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0;
    check_reset_values("midrun_reset");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      active = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) prescaler = PW'($urandom_range(0, 3));
      step = SW'($urandom);
      mtime_we = ($urandom_range(0, 49) == 0);
      mtime_wdata = TW'($urandom);
      for (int k = 0; k < N_CMP; k++) cmp_we[k] = ($urandom_range(0, 24) == 0);
      cmp_wdata = mtime_o + TW'($urandom_range(0, 80));
      if ($urandom_range(0, 39) == 0) mode = N_CMP'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < N_CMP; k++) period[k*TW +: TW] = TW'($urandom_range(0, 40));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
